// File: rtl/mac_engine_sync.sv
// Multi-lane signed MAC engine: one sample in flight, per-lane accumulator and tap
// counter, coefficient fetched from a synchronous-read memory, result on req/ack.
module mac_engine_sync #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int INPUT_SIZE = 8,
  parameter int ACC_WIDTH  = 19,
  parameter int SATURATE   = 0,
  parameter int LANE_WIDTH = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_req,
  output logic                         in_ack,
  input  logic [LANE_WIDTH-1:0]        in_lane,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_data,
  output logic                         out_req,
  input  logic                         out_ack,
  output logic [LANE_WIDTH-1:0]        out_lane,
  output logic signed [ACC_WIDTH-1:0]  data_out,
  output logic                         lane_err,
  output logic                         busy
);

  localparam int LANE_SLOTS = 1 << LANE_WIDTH;
  localparam int PROD_W     = 2 * DATA_WIDTH;
  localparam int EXT_W      = (ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP   = ADDR_WIDTH'(INPUT_SIZE - 1);
  localparam logic [LANE_WIDTH:0]   LANE_LIMIT = (LANE_WIDTH + 1)'(NUM_LANES);

  typedef enum logic [1:0] {IDLE, FETCH, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] sample_p0;
  logic [LANE_WIDTH-1:0]        lane_p0;
  logic signed [ACC_WIDTH-1:0]  acc [LANE_SLOTS];
  logic [ADDR_WIDTH-1:0]        tap_cnt [LANE_SLOTS];
  logic signed [ACC_WIDTH-1:0]  prod_p1;
  logic signed [ACC_WIDTH-1:0]  sum_p1;
  logic                         lane_ok;
  logic                         accept;
  logic                         last_tap;

  // Sign-extend or truncate the full-precision product to accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] fit_product(
    input logic signed [PROD_W-1:0] p
  );
    logic signed [EXT_W-1:0] ext;
    ext = EXT_W'(p);
    return ext[ACC_WIDTH-1:0];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if ((SATURATE != 0) && (s[ACC_WIDTH] != s[ACC_WIDTH-1]))
      return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return s[ACC_WIDTH-1:0];
  endfunction

  assign lane_ok  = ({1'b0, in_lane} < LANE_LIMIT);
  assign accept   = (state == IDLE) && in_req;
  assign last_tap = (tap_cnt[lane_p0] == LAST_TAP);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    in_ack    = 1'b0;
    out_req   = 1'b0;
    case (state)
      IDLE: begin
        in_ack = 1'b1;
        if (in_req && lane_ok) state_nxt = FETCH;
      end
      FETCH: state_nxt = MAC;
      MAC:   state_nxt = last_tap ? OUT : IDLE;
      OUT: begin
        out_req = 1'b1;
        if (out_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: sample and lane captured at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_p0 <= data_in;
      lane_p0   <= in_lane;
    end
  end

  // Stage p1: coefficient arrives in MAC, one cycle after the FETCH address.
  assign prod_p1 = fit_product(PROD_W'(sample_p0) * PROD_W'(mem_data));
  assign sum_p1  = acc_add(acc[lane_p0], prod_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANE_SLOTS; i++) begin
        acc[i]     <= '0;
        tap_cnt[i] <= '0;
      end
      mem_addr <= '0;
      data_out <= '0;
      out_lane <= '0;
      lane_err <= 1'b0;
    end else begin
      if (accept) begin
        if (lane_ok) mem_addr <= tap_cnt[in_lane];
        else         lane_err <= 1'b1;
      end
      if (state == MAC) begin
        acc[lane_p0] <= sum_p1;
        if (last_tap) begin
          data_out <= sum_p1;
          out_lane <= lane_p0;
        end else begin
          tap_cnt[lane_p0] <= tap_cnt[lane_p0] + ADDR_WIDTH'(1);
        end
      end
      if ((state == OUT) && out_ack) begin
        acc[lane_p0]     <= '0;
        tap_cnt[lane_p0] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_engine_sync.sv
// Directed bench for mac_engine_sync: default build plus saturating, wrapping
// 16-bit and three-lane variants driven from the same sample channel.
module tb_mac_engine_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_req, out_ack;
  logic [1:0]        in_lane;
  logic signed [7:0] data_in;
  logic signed [7:0] mem [16];

  logic in_ack, out_req, lane_err, busy;
  logic [3:0] mem_addr;
  logic signed [7:0] mem_data;
  logic [1:0] out_lane;
  logic signed [18:0] data_out;

  logic s1_in_ack, s1_out_req, s1_lane_err, s1_busy;
  logic [3:0] s1_mem_addr;
  logic signed [7:0] s1_mem_data;
  logic [1:0] s1_out_lane;
  logic signed [15:0] s1_data_out;

  logic s0_in_ack, s0_out_req, s0_lane_err, s0_busy;
  logic [3:0] s0_mem_addr;
  logic signed [7:0] s0_mem_data;
  logic [1:0] s0_out_lane;
  logic signed [15:0] s0_data_out;

  logic l3_in_ack, l3_out_req, l3_lane_err, l3_busy;
  logic [3:0] l3_mem_addr;
  logic signed [7:0] l3_mem_data;
  logic [1:0] l3_out_lane;
  logic signed [18:0] l3_data_out;

  mac_engine_sync dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack), .in_lane(in_lane),
    .data_in(data_in), .mem_addr(mem_addr), .mem_data(mem_data), .out_req(out_req),
    .out_ack(out_ack), .out_lane(out_lane), .data_out(data_out), .lane_err(lane_err),
    .busy(busy));

  mac_engine_sync #(.ACC_WIDTH(16), .SATURATE(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_req(in_req), .in_ack(s1_in_ack), .in_lane(in_lane),
    .data_in(data_in), .mem_addr(s1_mem_addr), .mem_data(s1_mem_data), .out_req(s1_out_req),
    .out_ack(out_ack), .out_lane(s1_out_lane), .data_out(s1_data_out), .lane_err(s1_lane_err),
    .busy(s1_busy));

  mac_engine_sync #(.ACC_WIDTH(16), .SATURATE(0)) dut_s0 (
    .clk(clk), .rst(rst), .in_req(in_req), .in_ack(s0_in_ack), .in_lane(in_lane),
    .data_in(data_in), .mem_addr(s0_mem_addr), .mem_data(s0_mem_data), .out_req(s0_out_req),
    .out_ack(out_ack), .out_lane(s0_out_lane), .data_out(s0_data_out), .lane_err(s0_lane_err),
    .busy(s0_busy));

  mac_engine_sync #(.NUM_LANES(3)) dut_l3 (
    .clk(clk), .rst(rst), .in_req(in_req), .in_ack(l3_in_ack), .in_lane(in_lane),
    .data_in(data_in), .mem_addr(l3_mem_addr), .mem_data(l3_mem_data), .out_req(l3_out_req),
    .out_ack(out_ack), .out_lane(l3_out_lane), .data_out(l3_data_out), .lane_err(l3_lane_err),
    .busy(l3_busy));

  // Synchronous-read coefficient memory, one read port per instance.
  always_ff @(posedge clk) begin
    mem_data    <= mem[mem_addr];
    s1_mem_data <= mem[s1_mem_addr];
    s0_mem_data <= mem[s0_mem_addr];
    l3_mem_data <= mem[l3_mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and return in the cycle after the accepting edge (FETCH).
  task automatic send(input int lane, input int data);
    int n;
    in_req  = 1'b1;
    in_lane = lane[1:0];
    data_in = data[7:0];
    n = 0;
    while (!in_ack && n < 20) begin
      tick();
      n++;
    end
    check("in_ack_wait", in_ack, 1);
    tick();
    in_req = 1'b0;
  endtask

  // Called right after the final send; leaves the bench in the first OUT cycle.
  task automatic wait_out(input int lane, input int exp, input string name);
    check({name, "_req_k1"}, out_req, 0);
    tick();
    check({name, "_req_k2"}, out_req, 0);
    tick();
    check({name, "_req_k3"}, out_req, 1);
    check({name, "_lane"}, out_lane, lane);
    check({name, "_data"}, data_out, exp);
    check({name, "_busy"}, busy, 1);
    check({name, "_in_ack"}, in_ack, 0);
  endtask

  task automatic do_ack(input string name);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check({name, "_req_after"}, out_req, 0);
    check({name, "_in_ack_after"}, in_ack, 1);
    check({name, "_busy_after"}, busy, 0);
  endtask

  typedef struct {
    int    lane;
    int    data;
    int    exp;
    string name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Coefficients i+1, so a constant sample d on eight taps gives 36*d.
    vecs[0] = '{0,    2,    72, "v_l0_p2"};
    vecs[1] = '{1,   -3,  -108, "v_l1_m3"};
    vecs[2] = '{2,  127,  4572, "v_l2_p127"};
    vecs[3] = '{3, -128, -4608, "v_l3_m128"};
    vecs[4] = '{0,    0,     0, "v_l0_zero"};
    vecs[5] = '{1,    1,    36, "v_l1_p1"};

    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    rst = 1'b1; in_req = 1'b1; in_lane = 2'd0; data_in = 8'sd7; out_ack = 1'b0;

    // Reset with a sample offered: nothing may be accepted.
    tick();
    check("rst_busy_1", busy, 0);
    tick();
    check("rst_busy_2", busy, 0);
    rst = 1'b0; in_req = 1'b0;
    check("rst_in_ack", in_ack, 1);
    check("rst_out_req", out_req, 0);
    check("rst_data_out", data_out, 0);
    check("rst_out_lane", out_lane, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_lane_err", lane_err, 0);
    check("rst_aux_busy", {s1_busy, s0_busy, l3_busy}, 0);
    check("rst_aux_err", {s1_lane_err, s0_lane_err, l3_lane_err}, 0);
    check("rst_aux_req", {s1_out_req, s0_out_req, l3_out_req}, 0);

    for (int v = 0; v < 6; v++) begin
      for (int t = 0; t < 8; t++) send(vecs[v].lane, vecs[v].data);
      wait_out(vecs[v].lane, vecs[v].exp, vecs[v].name);
      do_ack(vecs[v].name);
    end

    // Interleaved lanes 0 and 1 share the memory but not their state.
    for (int i = 0; i < 8; i++) begin
      send(0, 1);
      if (i == 7) begin
        wait_out(0, 36, "ilv_l0");
        do_ack("ilv_l0");
      end
      send(1, -1);
      if (i == 7) begin
        wait_out(1, -36, "ilv_l1");
        do_ack("ilv_l1");
      end
    end

    // Backpressure: result held for five extra cycles, then accumulator must be clear.
    for (int t = 0; t < 8; t++) send(0, 2);
    wait_out(0, 72, "bp");
    for (int h = 0; h < 5; h++) begin
      tick();
      check("bp_hold_req", out_req, 1);
      check("bp_hold_data", data_out, 72);
      check("bp_hold_in_ack", in_ack, 0);
    end
    do_ack("bp");
    for (int t = 0; t < 8; t++) send(0, 1);
    wait_out(0, 36, "bp_next");
    do_ack("bp_next");

    // Abort during MAC of tap 5 on lane 2.
    for (int t = 0; t < 6; t++) send(2, 1);
    tick();
    check("abort_in_mac", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_req", out_req, 0);
    check("abort_in_ack", in_ack, 1);
    check("abort_busy", busy, 0);
    check("abort_data_out", data_out, 0);
    for (int t = 0; t < 8; t++) send(2, 1);
    wait_out(2, 36, "abort_fresh");
    do_ack("abort_fresh");

    // Out-of-range lane on the three-lane build, mid-way through a lane 0 run.
    check("l3_err_clear", l3_lane_err, 0);
    for (int t = 0; t < 4; t++) send(0, 1);
    send(3, 5);
    check("l3_err_set", l3_lane_err, 1);
    check("l3_err_busy", l3_busy, 0);
    check("l3_err_in_ack", l3_in_ack, 1);
    check("main_no_err", lane_err, 0);
    tick();
    check("l3_err_busy2", l3_busy, 0);
    tick();
    for (int t = 0; t < 4; t++) send(0, 1);
    wait_out(0, 36, "l3_main");
    check("l3_out_req", l3_out_req, 1);
    check("l3_out_lane", l3_out_lane, 0);
    check("l3_data", l3_data_out, 36);
    check("l3_err_sticky", l3_lane_err, 1);
    do_ack("l3_main");

    // Saturation versus wrap on 16-bit accumulators: 8 * 16384 = 131072.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = -8'sd128;
    for (int t = 0; t < 8; t++) send(0, -128);
    wait_out(0, 131072, "sat_main");
    check("sat1_req", s1_out_req, 1);
    check("sat1_lane", s1_out_lane, 0);
    check("sat1_data", s1_data_out, 32767);
    check("sat1_in_ack", s1_in_ack, 0);
    check("sat0_req", s0_out_req, 1);
    check("sat0_lane", s0_out_lane, 0);
    check("sat0_data", s0_data_out, 0);
    check("sat0_in_ack", s0_in_ack, 0);
    do_ack("sat_main");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
